// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout fetches win every cycle they request,
// host commands queue in a small FIFO and drain in the remaining slots.
module vram_arbiter #(
   parameter int ADDR_W     = 15,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk_pixel,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] fetch_data,
   input  logic              host_valid,
   output logic              host_ready,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_rd_valid,
   output logic [DATA_W-1:0] host_rd_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic              stat_clear,
   output logic [15:0]       host_stall_cnt
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      TAG_NONE,
      TAG_FETCH,
      TAG_HOST
   } tag_t;

   logic [FIFO_DEPTH-1:0] r_fifo_we;
   logic [ADDR_W-1:0]     r_fifo_addr  [FIFO_DEPTH];
   logic [DATA_W-1:0]     r_fifo_wdata [FIFO_DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [PW:0]           r_count;
   logic                  r_host_ready;

   tag_t                  r_tag1;
   tag_t                  r_tag2;

   logic                  r_fetch_valid;
   logic [DATA_W-1:0]     r_fetch_data;
   logic                  r_host_rd_valid;
   logic [DATA_W-1:0]     r_host_rd_data;
   logic [ADDR_W-1:0]     r_ram_addr;
   logic                  r_ram_we;
   logic [DATA_W-1:0]     r_ram_wdata;
   logic [15:0]           r_stall_cnt;

   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic [PW:0]           w_count_nxt;
   logic                  w_head_we;
   logic [ADDR_W-1:0]     w_head_addr;
   logic [DATA_W-1:0]     w_head_wdata;

   assign w_empty      = (r_count == '0);
   assign w_push       = host_valid && r_host_ready;
   assign w_pop        = !fetch_req && !w_empty;
   assign w_head_we    = r_fifo_we[r_rd_ptr];
   assign w_head_addr  = r_fifo_addr[r_rd_ptr];
   assign w_head_wdata = r_fifo_wdata[r_rd_ptr];

   always_comb begin
      w_count_nxt = r_count;
      w_count_nxt = w_count_nxt + {{PW{1'b0}}, w_push};
      w_count_nxt = w_count_nxt - {{PW{1'b0}}, w_pop};
   end

   // Storage needs no reset: occupancy is tracked by r_count alone.
   always_ff @(posedge clk_pixel) begin
      if (w_push) begin
         r_fifo_we[r_wr_ptr]    <= host_we;
         r_fifo_addr[r_wr_ptr]  <= host_addr;
         r_fifo_wdata[r_wr_ptr] <= host_wdata;
      end
   end

   always_ff @(posedge clk_pixel or posedge rst) begin
      if (rst) begin
         r_wr_ptr        <= '0;
         r_rd_ptr        <= '0;
         r_count         <= '0;
         r_host_ready    <= 1'b0;
         r_tag1          <= TAG_NONE;
         r_tag2          <= TAG_NONE;
         r_fetch_valid   <= 1'b0;
         r_fetch_data    <= '0;
         r_host_rd_valid <= 1'b0;
         r_host_rd_data  <= '0;
         r_ram_addr      <= '0;
         r_ram_we        <= 1'b0;
         r_ram_wdata     <= '0;
         r_stall_cnt     <= '0;
      end else begin
         r_count      <= w_count_nxt;
         r_host_ready <= (w_count_nxt != FULL);
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

         if (fetch_req) begin
            r_ram_addr <= fetch_addr;
            r_ram_we   <= 1'b0;
            r_tag1     <= TAG_FETCH;
         end else if (w_pop) begin
            r_ram_addr <= w_head_addr;
            r_ram_we   <= w_head_we;
            if (w_head_we) r_ram_wdata <= w_head_wdata;
            r_tag1     <= w_head_we ? TAG_NONE : TAG_HOST;
         end else begin
            r_ram_we   <= 1'b0;
            r_tag1     <= TAG_NONE;
         end

         // RAM data for the stage-2 tag is on ram_rdata this cycle.
         r_tag2          <= r_tag1;
         r_fetch_valid   <= (r_tag2 == TAG_FETCH);
         r_host_rd_valid <= (r_tag2 == TAG_HOST);
         if (r_tag2 == TAG_FETCH) r_fetch_data   <= ram_rdata;
         if (r_tag2 == TAG_HOST)  r_host_rd_data <= ram_rdata;

         if (stat_clear)
            r_stall_cnt <= '0;
         else if (fetch_req && !w_empty && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign fetch_valid    = r_fetch_valid;
   assign fetch_data     = r_fetch_data;
   assign host_ready     = r_host_ready;
   assign host_rd_valid  = r_host_rd_valid;
   assign host_rd_data   = r_host_rd_data;
   assign ram_addr       = r_ram_addr;
   assign ram_we         = r_ram_we;
   assign ram_wdata      = r_ram_wdata;
   assign host_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised scoreboard bench for vram_arbiter with a queue-based
// reference model of the arbitration rules and a synchronous RAM.
module tb_vram_arbiter;

   localparam int AW = 15;
   localparam int DW = 8;
   localparam int MEMSZ = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fetch_req = 1'b0;
   logic [AW-1:0] fetch_addr = '0;
   logic          fetch_valid;
   logic [DW-1:0] fetch_data;
   logic          host_valid = 1'b0;
   logic          host_ready;
   logic          host_we = 1'b0;
   logic [AW-1:0] host_addr = '0;
   logic [DW-1:0] host_wdata = '0;
   logic          host_rd_valid;
   logic [DW-1:0] host_rd_data;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;
   logic          stat_clear = 1'b0;
   logic [15:0]   host_stall_cnt;

   vram_arbiter dut (
      .clk_pixel      (clk),
      .rst            (rst),
      .fetch_req      (fetch_req),
      .fetch_addr     (fetch_addr),
      .fetch_valid    (fetch_valid),
      .fetch_data     (fetch_data),
      .host_valid     (host_valid),
      .host_ready     (host_ready),
      .host_we        (host_we),
      .host_addr      (host_addr),
      .host_wdata     (host_wdata),
      .host_rd_valid  (host_rd_valid),
      .host_rd_data   (host_rd_data),
      .ram_addr       (ram_addr),
      .ram_we         (ram_we),
      .ram_wdata      (ram_wdata),
      .ram_rdata      (ram_rdata),
      .stat_clear     (stat_clear),
      .host_stall_cnt (host_stall_cnt)
   );

   initial forever #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Synchronous RAM and reference model share the same initial image.
   logic [DW-1:0] mem  [MEMSZ];
   logic [DW-1:0] mmem [MEMSZ];

   initial begin
      for (int i = 0; i < MEMSZ; i++) mem[i] = DW'((i * 37) ^ (i >> 7));
      forever begin
         @(posedge clk);
         if (ram_we) mem[ram_addr] <= ram_wdata;
         ram_rdata <= mem[ram_addr];
      end
   end

   typedef struct {
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } cmd_t;

   typedef struct {
      logic [DW-1:0] d;
      longint        cyc;
   } exp_t;

   cmd_t   pend[$];
   exp_t   fexp[$];
   exp_t   hexp[$];
   cmd_t   c;
   bit     wp_v = 0;
   cmd_t   wp;
   int     m_stall = 0;
   bit     m_ready = 0;
   bit     push_ok;
   longint cyc = 0;

   initial begin
      for (int i = 0; i < MEMSZ; i++) mmem[i] = DW'((i * 37) ^ (i >> 7));
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            pend.delete();
            fexp.delete();
            hexp.delete();
            wp_v    = 0;
            m_stall = 0;
            m_ready = 0;
         end else begin
            cyc++;
            // A write issued last cycle lands in RAM at this edge.
            if (wp_v) mmem[wp.a] = wp.d;
            wp_v = 0;
            if (stat_clear) m_stall = 0;
            else if (fetch_req && pend.size() != 0 && m_stall < 65535)
               m_stall++;
            push_ok = host_valid && m_ready;
            if (fetch_req) begin
               fexp.push_back('{mmem[fetch_addr], cyc + 2});
            end else if (pend.size() != 0) begin
               c = pend.pop_front();
               if (c.we) begin
                  wp_v = 1;
                  wp   = c;
               end else begin
                  hexp.push_back('{mmem[c.a], cyc + 2});
               end
            end
            if (push_ok) pend.push_back('{host_we, host_addr, host_wdata});
            m_ready = (pend.size() < 4);
         end
      end
   end

   exp_t e;
   always @(negedge clk) begin
      chk("host_ready", host_ready, m_ready);
      chk("stall_cnt", host_stall_cnt, m_stall);
      if (fetch_valid) begin
         if (fexp.size() == 0) begin
            chk("fetch_spurious", 1, 0);
         end else begin
            e = fexp.pop_front();
            chk("fetch_data", fetch_data, e.d);
            chk("fetch_latency", cyc, e.cyc);
         end
      end
      if (host_rd_valid) begin
         if (hexp.size() == 0) begin
            chk("host_rd_spurious", 1, 0);
         end else begin
            e = hexp.pop_front();
            chk("host_rd_data", host_rd_data, e.d);
            chk("host_rd_latency", cyc, e.cyc);
         end
      end
   end

   task automatic host_cmd(input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
      int t;
      bit acc;
      t = 0;
      host_valid = 1'b1;
      host_we    = we;
      host_addr  = a;
      host_wdata = d;
      do begin
         acc = host_ready;
         @(negedge clk);
         t++;
      end while (!acc && t < 2000);
      host_valid = 1'b0;
      if (!acc) chk("host_accept_timeout", 0, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ram_we"}, ram_we, 0);
      chk({tag, "_ram_addr"}, ram_addr, 0);
      chk({tag, "_ram_wdata"}, ram_wdata, 0);
      chk({tag, "_host_ready"}, host_ready, 0);
      chk({tag, "_fetch_valid"}, fetch_valid, 0);
      chk({tag, "_fetch_data"}, fetch_data, 0);
      chk({tag, "_host_rd_valid"}, host_rd_valid, 0);
      chk({tag, "_host_rd_data"}, host_rd_data, 0);
      chk({tag, "_stall"}, host_stall_cnt, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [AW-1:0] waddr[$];
   logic [AW-1:0] a;
   int            t;

   initial begin
      // Power-on reset.
      idle(3);
      check_reset_outputs("por");
      rst = 1'b0;
      idle(1);
      chk("ready_after_reset", host_ready, 1);

      // Idle host: write then read back the same byte.
      host_valid = 1'b1; host_we = 1'b1;
      host_addr = 15'h1234; host_wdata = 8'hA5;
      @(negedge clk);
      host_we = 1'b0;
      @(negedge clk);
      host_valid = 1'b0;
      chk("idle_wr_we", ram_we, 1);
      chk("idle_wr_addr", ram_addr, 15'h1234);
      chk("idle_wr_data", ram_wdata, 8'hA5);
      @(negedge clk);
      chk("idle_rd_we", ram_we, 0);
      chk("idle_rd_addr", ram_addr, 15'h1234);
      idle(4);

      // Collision: fetch wins over a queued host write.
      host_valid = 1'b1; host_we = 1'b1;
      host_addr = 15'h0200; host_wdata = 8'h3C;
      @(negedge clk);
      host_valid = 1'b0;
      fetch_req = 1'b1; fetch_addr = 15'h0100;
      @(negedge clk);
      fetch_req = 1'b0;
      chk("coll_fetch_addr", ram_addr, 15'h0100);
      chk("coll_fetch_we", ram_we, 0);
      chk("coll_stall", host_stall_cnt, 1);
      @(negedge clk);
      chk("coll_host_we", ram_we, 1);
      chk("coll_host_addr", ram_addr, 15'h0200);
      idle(4);

      // FIFO full while scanout holds every slot.
      fetch_req = 1'b1;
      fork
         begin
            repeat (12) begin
               fetch_addr = AW'($urandom_range(0, MEMSZ - 1));
               @(negedge clk);
            end
            fetch_req = 1'b0;
         end
         begin
            host_cmd(1'b1, 15'h0400, 8'h11);
            host_cmd(1'b0, 15'h0400, 8'h00);
            host_cmd(1'b1, 15'h0400, 8'h22);
            host_cmd(1'b0, 15'h0400, 8'h00);
            chk("full_ready_low", host_ready, 0);
            host_cmd(1'b0, 15'h0400, 8'h00);
         end
      join
      idle(6);

      // Scanout cadence against a streaming host.
      fork
         begin
            repeat (64) begin
               fetch_req  = 1'b1;
               fetch_addr = AW'($urandom_range(0, MEMSZ - 1));
               @(negedge clk);
               fetch_req = 1'b0;
               idle(7);
            end
         end
         begin
            repeat (500) begin
               a = AW'($urandom_range(0, MEMSZ - 1));
               waddr.push_back(a);
               host_cmd(1'b1, a, DW'($urandom));
            end
         end
      join
      for (int i = 0; i < 16; i++)
         host_cmd(1'b0, waddr[499 - i * 7], 8'h00);
      idle(8);
      chk("cadence_stall_nonzero", (host_stall_cnt != 0), 1);
      stat_clear = 1'b1;
      @(negedge clk);
      stat_clear = 1'b0;
      chk("stat_clear", host_stall_cnt, 0);

      // Reset while a write is on the RAM port and a read is in flight.
      host_cmd(1'b0, 15'h0301, 8'h00);
      host_cmd(1'b1, 15'h0301, 8'h77);
      @(negedge clk);
      chk("rst_pre_we", ram_we, 1);
      #2 rst = 1'b1;
      #1 check_reset_outputs("midrst");
      idle(3);
      rst = 1'b0;
      idle(2);
      host_cmd(1'b0, 15'h0301, 8'h00);
      idle(6);

      // Stall counter saturation.
      fetch_req = 1'b1; fetch_addr = 15'h0042;
      host_cmd(1'b1, 15'h0500, 8'h5A);
      repeat (70000) begin
         fetch_addr = AW'($urandom_range(0, MEMSZ - 1));
         @(negedge clk);
      end
      chk("sat_hold", host_stall_cnt, 16'hFFFF);
      fetch_req = 1'b0;
      idle(6);

      t = 0;
      while ((pend.size() != 0 || fexp.size() != 0 || hexp.size() != 0)
             && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("drain_pend", pend.size(), 0);
      chk("drain_fetch", fexp.size(), 0);
      chk("drain_host", hexp.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video RAM arbiter that shares the framebuffer between the scanout path (8-pixel character fetches during active display) and the host (Raspberry Pi) command port. Scanout has absolute priority; host reads and writes are queued in a small command FIFO and drained in every cycle the scanout does not claim. The block sits between the raster timing/scanout logic and the external synchronous RAM on the pixel clock domain.

## Interface

- ADDR_W, 15, byte address width (512x240 px, 1 bpp, red and green planes = 30720 bytes)
- DATA_W, 8, data width (one character cell of 8 pixels)
- FIFO_DEPTH, 4, host command FIFO entries (power of two, >= 2)

- clk_pixel  in  1  pixel clock (19.6608 MHz); all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- fetch_req  in  1  scanout read request, one-cycle pulse
- fetch_addr  in  ADDR_W  scanout byte address
- fetch_valid  out  1  one-cycle pulse, fetch_data valid
- fetch_data  out  DATA_W  scanout read data
- host_valid  in  1  host command offered
- host_ready  out  1  FIFO can accept a command
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host byte address
- host_wdata  in  DATA_W  host write data
- host_rd_valid  out  1  one-cycle pulse, host_rd_data valid
- host_rd_data  out  DATA_W  host read data
- ram_addr  out  ADDR_W  RAM address (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_wdata  out  DATA_W  RAM write data (registered)
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_addr/ram_we=0
- stat_clear  in  1  synchronous clear of host_stall_cnt
- host_stall_cnt  out  16  cycles a queued host command lost to scanout, saturating

## Operation

- Command FIFO: entry = {we, addr, wdata}; push when host_valid && host_ready; host_ready = registered !full; no push-bypass when full (push and pop in the same full cycle: pop only).
- Arbitration each cycle, priority order: fetch_req -> issue read at fetch_addr; else FIFO non-empty -> pop head, issue its read/write; else idle (ram_we=0, ram_addr/ram_wdata hold).
- Host commands issue strictly in FIFO order; no reordering, no forwarding. Host read after host write to same address returns written data (RAM sequential).
- Return tagging: 2-stage tag pipeline {NONE, FETCH, HOST} follows each issued read; writes tag NONE. Stage-2 tag steers ram_rdata into fetch_data or host_rd_data with matching valid pulse.
- fetch_data/host_rd_data hold last value between pulses.
- Stall counter: +1 every cycle fetch_req && FIFO non-empty; saturates at 0xFFFF; stat_clear has priority over increment.
- fetch_req back-to-back is legal; host fully starves while it persists (scanout normally issues at most 1 per 8 cycles, leaving host >= 7 of 8 slots).

## Timing

- Reset values: host_ready=0, fetch_valid=0, host_rd_valid=0, fetch_data=0, host_rd_data=0, ram_addr=0, ram_we=0, ram_wdata=0, host_stall_cnt=0; FIFO empty, tags NONE.
- host_ready rises on the first clk_pixel edge after rst deasserts.
- Request sampled at edge k: ram_addr/ram_we updated at edge k; ram_rdata valid after edge k+1; fetch_valid/host_rd_valid high in the cycle after edge k+2 (latency 2 edges, fixed, independent of load).
- Host command latency from push: 1 edge minimum (push at k, earliest issue at k+1) plus 1 edge per scanout-won cycle and per older queued entry.
- Reset mid-operation: FIFO contents and in-flight tags discarded; no valid pulse emitted for reads issued before rst; ram_we drops asynchronously.
- FIFO full: host_ready low in the cycle after the filling push; rises the cycle after a pop.

## Test plan

- Reset mid-write: rst asserted while ram_we=1 -> ram_we=0 immediately, all outputs at reset values, no stale host_rd_valid after release.
- Idle host: write 0xA5 to 0x1234 then read 0x1234 -> ram_we=1 at edge k, read issued k+1, host_rd_valid with 0xA5 at k+3.
- Collision: fetch_req (addr 0x0100) and queued host write same cycle -> read 0x0100 issued first, host write next cycle, host_stall_cnt=1; fetch_valid exactly 2 edges after request.
- FIFO full: push 4 commands while fetch_req held high -> host_ready=0 after 4th push, 5th host_valid not accepted; release fetch_req -> entries drain in order, host_ready returns 1.
- Scanout cadence: fetch_req every 8 cycles for 64 fetches with host streaming 500 writes -> every fetch returns in 2 edges, all writes land, host_stall_cnt equals overlap count; stat_clear -> 0.
- Saturation: host_stall_cnt forced near 0xFFFF by 70000 stall cycles -> holds 0xFFFF.
